// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Provides the FSM state encoding, register-address width, the zero-register
// constant and a small source-operand match helper.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REGADDR_W = 5;
    localparam int unsigned STATE_W   = 3;
    localparam int unsigned BUB_W     = 3;

    localparam logic [REGADDR_W-1:0] ZERO_REG = REGADDR_W'(0);

    // Controller states; the encoding is visible on ctrl_state for debug.
    typedef enum logic [STATE_W-1:0] {
        HZ_RUN   = 3'd0,
        HZ_MC    = 3'd1,
        HZ_MEM   = 3'd2,
        HZ_FLUSH = 3'd3
    } hz_state_e;

    // True when an ID source operand is read and names the given destination.
    function automatic logic src_hits(
        input logic                 used,
        input logic [REGADDR_W-1:0] rs,
        input logic [REGADDR_W-1:0] rd
    );
        return used && (rs == rd);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle.
// master : datapath side, drives ID/EX/LS status, receives hold/bubble controls.
// slave  : controller side, receives status, drives pc/ifid/idex/exls controls,
//          mc_kill and the ctrl_state debug view.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    // Status from the datapath
    logic [REGADDR_W-1:0] id_rs1_addr;
    logic [REGADDR_W-1:0] id_rs2_addr;
    logic                 id_rs1_used;
    logic                 id_rs2_used;
    logic [REGADDR_W-1:0] ex_rd_addr;
    logic                 ex_rd_ena;
    logic                 ex_load_flag;
    logic                 ex_mc_start;
    logic                 ex_mc_done;
    logic                 ex_redirect;
    logic                 ls_trap;
    logic                 ls_mem_busy;

    // Controls back to the datapath
    logic                 pc_stall;
    logic                 ifid_stall;
    logic                 ifid_flush;
    logic                 idex_stall;
    logic                 idex_flush;
    logic                 exls_stall;
    logic                 exls_flush;
    logic                 mc_kill;
    logic [STATE_W-1:0]   ctrl_state;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               ex_rd_addr, ex_rd_ena, ex_load_flag, ex_mc_start, ex_mc_done,
               ex_redirect, ls_trap, ls_mem_busy,
        input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exls_stall, exls_flush, mc_kill, ctrl_state
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               ex_rd_addr, ex_rd_ena, ex_load_flag, ex_mc_start, ex_mc_done,
               ex_redirect, ls_trap, ls_mem_busy,
        output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exls_stall, exls_flush, mc_kill, ctrl_state
    );

endinterface

// File: rtl/pipe_hazard_detect.sv
// Purely combinational load-use comparator.
// Ports:
//   i_rs1_addr/i_rs2_addr : ID source registers
//   i_rs1_used/i_rs2_used : ID actually reads the source
//   i_rd_addr/i_rd_ena    : EX destination and write enable
//   i_load_flag           : EX instruction is a load
//   o_load_use            : ID needs the load result that EX has not produced yet
module pipe_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REGADDR_W-1:0] i_rs1_addr,
    input  logic [REGADDR_W-1:0] i_rs2_addr,
    input  logic                 i_rs1_used,
    input  logic                 i_rs2_used,
    input  logic [REGADDR_W-1:0] i_rd_addr,
    input  logic                 i_rd_ena,
    input  logic                 i_load_flag,
    output logic                 o_load_use
);

    logic w_src_match;

    assign w_src_match = src_hits(i_rs1_used, i_rs1_addr, i_rd_addr)
                       | src_hits(i_rs2_used, i_rs2_addr, i_rd_addr);

    // Writes to x0 are discarded, so they can never create a dependency.
    assign o_load_use = i_load_flag & i_rd_ena & (i_rd_addr != ZERO_REG) & w_src_match;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Resolves, highest priority first: LS trap, EX redirect, LS memory wait,
// multi-cycle EX op, load-use. Controls are combinational from the state and
// the current inputs; state, bubble counter and perf counters are registered.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   hz       : pipe_hazard_ctrl_if.slave (status in, hold/bubble controls out)
//   perf_*   : saturating event counters, present only with
//              YSYX_22051013_PERF_CNT_EN defined
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REDIRECT_BUBBLES = 1,
    parameter int unsigned PERF_W           = 32
)(
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   hz
`ifdef YSYX_22051013_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]   perf_lu_cnt,
    output logic [PERF_W-1:0]   perf_mc_cnt,
    output logic [PERF_W-1:0]   perf_mem_cnt,
    output logic [PERF_W-1:0]   perf_flush_cnt
`endif
);

    // Elaboration-time parameter sanity.
    if (REDIRECT_BUBBLES < 1 || REDIRECT_BUBBLES > 7) begin : g_bad_redirect_bubbles
        $error("pipe_hazard_ctrl: REDIRECT_BUBBLES must be 1..7");
    end
    if (PERF_W < 1) begin : g_bad_perf_w
        $error("pipe_hazard_ctrl: PERF_W must be at least 1");
    end

    hz_state_e          r_state;
    hz_state_e          w_state_nxt;
    logic [BUB_W-1:0]   r_bub_cnt;
    logic [BUB_W-1:0]   w_bub_nxt;
    logic               w_load_use;

    logic w_pc_stall;
    logic w_ifid_stall;
    logic w_ifid_flush;
    logic w_idex_stall;
    logic w_idex_flush;
    logic w_exls_stall;
    logic w_exls_flush;
    logic w_mc_kill;

    pipe_hazard_detect u_detect (
        .i_rs1_addr  (hz.id_rs1_addr),
        .i_rs2_addr  (hz.id_rs2_addr),
        .i_rs1_used  (hz.id_rs1_used),
        .i_rs2_used  (hz.id_rs2_used),
        .i_rd_addr   (hz.ex_rd_addr),
        .i_rd_ena    (hz.ex_rd_ena),
        .i_load_flag (hz.ex_load_flag),
        .o_load_use  (w_load_use)
    );

    // Priority resolution and next-state; each branch asserts either the hold
    // or the bubble of a register, never both.
    always_comb begin
        w_state_nxt  = r_state;
        w_bub_nxt    = r_bub_cnt;
        w_pc_stall   = 1'b0;
        w_ifid_stall = 1'b0;
        w_ifid_flush = 1'b0;
        w_idex_stall = 1'b0;
        w_idex_flush = 1'b0;
        w_exls_stall = 1'b0;
        w_exls_flush = 1'b0;
        w_mc_kill    = 1'b0;

        if (hz.ls_trap) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            w_exls_flush = 1'b1;
            w_mc_kill    = (r_state == HZ_MC);
            w_state_nxt  = HZ_FLUSH;
            w_bub_nxt    = BUB_W'(REDIRECT_BUBBLES);
        end else if (hz.ex_redirect && !hz.ls_mem_busy && r_state != HZ_MC) begin
            // EX holds the multi-cycle op while in HZ_MC, so no redirect can
            // originate there; a redirect during memory wait is held in EX.
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            w_state_nxt  = HZ_FLUSH;
            w_bub_nxt    = BUB_W'(REDIRECT_BUBBLES);
        end else if (hz.ls_mem_busy && r_state != HZ_MC) begin
            // LS carries a bubble during HZ_MC, so busy is only meaningful
            // elsewhere. A FLUSH sequence is frozen, not abandoned.
            w_pc_stall   = 1'b1;
            w_ifid_stall = 1'b1;
            w_idex_stall = 1'b1;
            w_exls_stall = 1'b1;
            if (r_state != HZ_FLUSH) begin
                w_state_nxt = HZ_MEM;
            end
        end else begin
            case (r_state)
                HZ_MC: begin
                    if (hz.ex_mc_done) begin
                        w_state_nxt = HZ_RUN;
                    end else begin
                        w_pc_stall   = 1'b1;
                        w_ifid_stall = 1'b1;
                        w_idex_stall = 1'b1;
                        w_exls_flush = 1'b1;
                    end
                end
                HZ_FLUSH: begin
                    w_ifid_flush = 1'b1;
                    if (r_bub_cnt != BUB_W'(0)) begin
                        w_bub_nxt = r_bub_cnt - BUB_W'(1);
                    end
                    if (r_bub_cnt <= BUB_W'(1)) begin
                        w_state_nxt = HZ_RUN;
                    end
                end
                default: begin
                    // RUN, or the first non-busy cycle of MEM_WAIT which
                    // behaves as RUN so a pending dependency is not skipped.
                    w_state_nxt = HZ_RUN;
                    if (hz.ex_mc_start && !hz.ex_mc_done) begin
                        w_state_nxt = HZ_MC;
                    end else if (w_load_use) begin
                        w_pc_stall   = 1'b1;
                        w_ifid_stall = 1'b1;
                        w_idex_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    // State and bubble counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= HZ_RUN;
            r_bub_cnt <= BUB_W'(0);
        end else begin
            r_state   <= w_state_nxt;
            r_bub_cnt <= w_bub_nxt;
        end
    end

    // Controls are forced low while reset is asserted, independent of inputs.
    assign hz.pc_stall   = w_pc_stall   & ~rst;
    assign hz.ifid_stall = w_ifid_stall & ~rst;
    assign hz.ifid_flush = w_ifid_flush & ~rst;
    assign hz.idex_stall = w_idex_stall & ~rst;
    assign hz.idex_flush = w_idex_flush & ~rst;
    assign hz.exls_stall = w_exls_stall & ~rst;
    assign hz.exls_flush = w_exls_flush & ~rst;
    assign hz.mc_kill    = w_mc_kill    & ~rst;
    assign hz.ctrl_state = r_state;

`ifdef YSYX_22051013_PERF_CNT_EN
    logic [PERF_W-1:0] r_perf_lu;
    logic [PERF_W-1:0] r_perf_mc;
    logic [PERF_W-1:0] r_perf_mem;
    logic [PERF_W-1:0] r_perf_flush;
    logic              w_win_lu;
    logic              w_win_mc;
    logic              w_win_mem;
    logic              w_win_flush;

    // Winning cause recovered from the control pattern each cause produces.
    assign w_win_flush = w_ifid_flush;
    assign w_win_lu    = w_idex_flush & ~w_ifid_flush;
    assign w_win_mem   = w_exls_stall;
    assign w_win_mc    = w_idex_stall & ~w_exls_stall;

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_lu    <= PERF_W'(0);
            r_perf_mc    <= PERF_W'(0);
            r_perf_mem   <= PERF_W'(0);
            r_perf_flush <= PERF_W'(0);
        end else begin
            if (w_win_lu && (r_perf_lu != '1)) begin
                r_perf_lu <= r_perf_lu + PERF_W'(1);
            end
            if (w_win_mc && (r_perf_mc != '1)) begin
                r_perf_mc <= r_perf_mc + PERF_W'(1);
            end
            if (w_win_mem && (r_perf_mem != '1)) begin
                r_perf_mem <= r_perf_mem + PERF_W'(1);
            end
            if (w_win_flush && (r_perf_flush != '1)) begin
                r_perf_flush <= r_perf_flush + PERF_W'(1);
            end
        end
    end

    assign perf_lu_cnt    = r_perf_lu;
    assign perf_mc_cnt    = r_perf_mc;
    assign perf_mem_cnt   = r_perf_mem;
    assign perf_flush_cnt = r_perf_flush;
`endif

endmodule
